// File: rtl/oflow_buffer_pkg.sv
// Shared types and default widths for the oflow MEM buffer sequencers.
package oflow_buffer_pkg;

    localparam int BUF_NUM_SLOTS                   = 5;
    localparam int BUF_ADDR_WIDTH                  = 8;
    localparam int BUF_OFFSET_WIDTH                = 8;
    localparam int BUF_TOTAL_FRAME_NUM_WIDTH       = 8;
    localparam int BUF_NUM_OF_HISTORY_FRAMES_WIDTH = 3;
    localparam int BUF_SLOT_WIDTH                  = 3;

    // Read sequencer states; also decoded by the wrapper's debug mux.
    typedef enum logic [2:0] {
        BUF_RD_IDLE  = 3'd0,
        BUF_RD_SETUP = 3'd1,
        BUF_RD_FRAME = 3'd2,
        BUF_RD_PAIR  = 3'd3,
        BUF_RD_DONE  = 3'd4
    } buf_rd_state_t;

endpackage

// File: rtl/oflow_fsm_buffer_read_if.sv
// Core <-> buffer-read handshake: start/accept from the core, address pairs back.
interface oflow_fsm_buffer_read_if
    import oflow_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = BUF_ADDR_WIDTH
);
    logic                      start_read;
    logic                      ready_from_core;
    logic                      valid_read;
    logic [BUF_SLOT_WIDTH-1:0] slot;
    logic [ADDR_WIDTH-1:0]     offset_0;
    logic [ADDR_WIDTH-1:0]     offset_1;
    logic                      valid_1;
    logic                      done_read;

    modport master (
        output start_read, ready_from_core,
        input  valid_read, slot, offset_0, offset_1, valid_1, done_read
    );

    modport slave (
        input  start_read, ready_from_core,
        output valid_read, slot, offset_0, offset_1, valid_1, done_read
    );
endinterface

// File: rtl/oflow_slot_step.sv
// Previous frame slot with wrap at the history depth nh (slot 0 -> nh-1).
module oflow_slot_step #(
    parameter int SLOT_W = 3,
    parameter int NH_W   = 3
) (
    input  logic [SLOT_W-1:0] slot,
    input  logic [NH_W-1:0]   nh,
    output logic [SLOT_W-1:0] prev
);
    logic [NH_W-1:0] nh_m1;

    assign nh_m1 = nh - NH_W'(1);
    assign prev  = (slot == '0) ? SLOT_W'(nh_m1) : slot - SLOT_W'(1);
endmodule

// File: rtl/oflow_fsm_buffer_read.sv
// Buffer read sequencer: walks history slots newest first, presenting
// bbox line addresses two at a time until the core accepts each pair.
module oflow_fsm_buffer_read
    import oflow_buffer_pkg::*;
#(
    parameter int NUM_SLOTS                   = BUF_NUM_SLOTS,
    parameter int ADDR_WIDTH                  = BUF_ADDR_WIDTH,
    parameter int TOTAL_FRAME_NUM_WIDTH       = BUF_TOTAL_FRAME_NUM_WIDTH,
    parameter int NUM_OF_HISTORY_FRAMES_WIDTH = BUF_NUM_OF_HISTORY_FRAMES_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   reset_N,
    input  logic [TOTAL_FRAME_NUM_WIDTH-1:0]       frame_num,
    input  logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] num_of_history_frames,
    input  logic [NUM_SLOTS-1:0][ADDR_WIDTH-1:0]   end_pointers,
    oflow_fsm_buffer_read_if.slave                 rd_if
);
    localparam int SW = BUF_SLOT_WIDTH;
    localparam int HW = NUM_OF_HISTORY_FRAMES_WIDTH;
    localparam int FW = TOTAL_FRAME_NUM_WIDTH;

    localparam logic [2:0] ST_IDLE  = BUF_RD_IDLE;
    localparam logic [2:0] ST_SETUP = BUF_RD_SETUP;
    localparam logic [2:0] ST_FRAME = BUF_RD_FRAME;
    localparam logic [2:0] ST_PAIR  = BUF_RD_PAIR;
    localparam logic [2:0] ST_DONE  = BUF_RD_DONE;

    logic [2:0]                           state;
    logic [FW-1:0]                        fn_q;
    logic [HW-1:0]                        nh_q;
    logic [NUM_SLOTS-1:0][ADDR_WIDTH-1:0] cnt_q;
    logic [SW-1:0]                        slot_q;
    logic [FW-1:0]                        left_q;
    logic [ADDR_WIDTH-1:0]                off0_q, off1_q;
    logic                                 v1_q, valid_q, done_q;

    logic [HW-1:0]         nh_m1;
    logic [FW-1:0]         fn_mod;
    logic [SW-1:0]         setup_slot, slot_prev;
    logic [FW-1:0]         setup_left;
    logic [ADDR_WIDTH-1:0] cur_cnt;
    logic [ADDR_WIDTH:0]   cnt_ext, next2;

    // Start slot and history length, derived once from the snapshot.
    assign nh_m1      = nh_q - HW'(1);
    assign fn_mod     = fn_q % FW'(nh_q);
    assign setup_slot = (fn_mod == '0) ? SW'(nh_m1) : SW'(fn_mod - FW'(1));
    assign setup_left = (fn_q < FW'(nh_m1)) ? fn_q : FW'(nh_m1);

    // Count of the slot under the cursor; ADDR_WIDTH+1 bits so a full slot never wraps.
    always_comb begin
        cur_cnt = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            if (slot_q == SW'(i)) cur_cnt = cnt_q[i];
    end

    assign cnt_ext = {1'b0, cur_cnt};
    assign next2   = {1'b0, off0_q} + (ADDR_WIDTH+1)'(2);

    oflow_slot_step #(.SLOT_W(SW), .NH_W(HW)) u_slot_step (
        .slot (slot_q),
        .nh   (nh_q),
        .prev (slot_prev)
    );

    // Sequencer: snapshot, setup, per-frame scan and pair handshake.
    always_ff @(posedge clk) begin
        if (reset_N) begin
            state   <= ST_IDLE;
            fn_q    <= '0;
            nh_q    <= HW'(1);
            cnt_q   <= '0;
            slot_q  <= '0;
            left_q  <= '0;
            off0_q  <= '0;
            off1_q  <= '0;
            v1_q    <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rd_if.start_read) begin
                        fn_q  <= frame_num;
                        nh_q  <= (num_of_history_frames == '0) ? HW'(1) : num_of_history_frames;
                        cnt_q <= end_pointers;
                        state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    slot_q <= setup_slot;
                    left_q <= setup_left;
                    state  <= ST_FRAME;
                end
                ST_FRAME: begin
                    if (left_q == '0) begin
                        done_q <= 1'b1;
                        state  <= ST_DONE;
                    end else if (cur_cnt == '0) begin
                        left_q <= left_q - FW'(1);
                        slot_q <= slot_prev;
                    end else begin
                        off0_q  <= '0;
                        off1_q  <= ADDR_WIDTH'(1);
                        v1_q    <= cnt_ext > (ADDR_WIDTH+1)'(1);
                        valid_q <= 1'b1;
                        state   <= ST_PAIR;
                    end
                end
                ST_PAIR: begin
                    if (rd_if.ready_from_core) begin
                        if (next2 >= cnt_ext) begin
                            valid_q <= 1'b0;
                            left_q  <= left_q - FW'(1);
                            slot_q  <= slot_prev;
                            state   <= ST_FRAME;
                        end else begin
                            off0_q <= next2[ADDR_WIDTH-1:0];
                            off1_q <= next2[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);
                            v1_q   <= (next2 + (ADDR_WIDTH+1)'(1)) < cnt_ext;
                        end
                    end
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign rd_if.valid_read = valid_q;
    assign rd_if.slot       = slot_q;
    assign rd_if.offset_0   = off0_q;
    assign rd_if.offset_1   = off1_q;
    assign rd_if.valid_1    = v1_q;
    assign rd_if.done_read  = done_q;

endmodule

// File: tb/tb_oflow_fsm_buffer_read.sv
// Bench for oflow_fsm_buffer_read: directed table, hand sequences, random reads.
module tb_oflow_fsm_buffer_read;
    import oflow_buffer_pkg::*;

    localparam int NS = BUF_NUM_SLOTS;
    localparam int AW = BUF_ADDR_WIDTH;
    localparam int FW = BUF_TOTAL_FRAME_NUM_WIDTH;
    localparam int HW = BUF_NUM_OF_HISTORY_FRAMES_WIDTH;

    logic                   clk = 1'b0;
    logic                   reset_N;
    logic [FW-1:0]          frame_num;
    logic [HW-1:0]          nh;
    logic [NS-1:0][AW-1:0]  ep;

    oflow_fsm_buffer_read_if #(.ADDR_WIDTH(AW)) rd_if ();

    oflow_fsm_buffer_read dut (
        .clk                   (clk),
        .reset_N               (reset_N),
        .frame_num             (frame_num),
        .num_of_history_frames (nh),
        .end_pointers          (ep),
        .rd_if                 (rd_if)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    int obs_q[$];

    typedef struct {
        int fn;
        int nh;
        int cnt[NS];
        int mode;       // 0: ready held 1, 1: ready every 4th cycle, 2: random ready
        int exp_pairs;  // -1: no constant expectation
        int exp_lat;    // cycles from start edge to done_read, -1: none
    } vec_t;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int enc(input int s, input int o0, input int o1, input int v1);
        return (s << 20) | (o0 << 10) | (o1 << 1) | v1;
    endfunction

    // Reference: history frames are fn-1, fn-2, ... living in slot (fn-k) mod nh;
    // each frame is sent as ceil(count/2) pairs. Timing with ready held high:
    // 2 cycles to first FRAME visit/DONE, plus one FRAME cycle per frame and one per pair.
    function automatic void build_model(input int fn, input int nhv, input int cnt[NS],
                                        output int cycles);
        int n;
        int frames;
        int s;
        n = (nhv == 0) ? 1 : nhv;
        frames = (fn < n - 1) ? fn : n - 1;
        exp_q.delete();
        cycles = 2;
        for (int k = 1; k <= frames; k++) begin
            s = (fn - k) % n;
            cycles += 1;
            for (int i = 0; i < cnt[s]; i += 2) begin
                exp_q.push_back(enc(s, i, i + 1, (i + 1 < cnt[s]) ? 1 : 0));
                cycles += 1;
            end
        end
    endfunction

    function automatic int cur_out();
        return enc(rd_if.slot, rd_if.offset_0, rd_if.offset_1, rd_if.valid_1);
    endfunction

    task automatic run_read(input string tag, input int fn, input int nhv, input int cnt[NS],
                            input int mode, input int exp_pairs, input int exp_lat,
                            input bit perturb);
        int  lat;
        int  done_cnt;
        int  done_at;
        bit  holding;
        int  held;
        int  cur;
        bit  rdy;
        done_cnt = 0;
        done_at  = -1;
        holding  = 1'b0;
        held     = 0;
        build_model(fn, nhv, cnt, lat);
        obs_q.delete();
        frame_num = FW'(fn);
        nh        = HW'(nhv);
        for (int i = 0; i < NS; i++) ep[i] = AW'(cnt[i]);
        rd_if.start_read      = 1'b1;
        rd_if.ready_from_core = 1'b0;
        @(posedge clk); #1;
        rd_if.start_read = 1'b0;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            @(posedge clk); #1;
            if (perturb) begin
                if (cyc == 1) ep[3] = AW'(9);
                rd_if.start_read = (cyc == 4);
            end
            cur = cur_out();
            if (rd_if.done_read) begin
                done_cnt++;
                if (done_at < 0) done_at = cyc;
            end
            if (holding) chk({tag, "_hold_valid"}, rd_if.valid_read, 1);
            if (rd_if.valid_read) begin
                if (holding) chk({tag, "_hold_stable"}, cur, held);
                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = (cyc % 4 == 0);
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                if (rdy) begin
                    obs_q.push_back(cur);
                    holding = 1'b0;
                end else begin
                    holding = 1'b1;
                    held    = cur;
                end
            end else begin
                holding = 1'b0;
                rdy = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            rd_if.ready_from_core = rdy;
            if (done_at >= 0 && cyc >= done_at + 3) break;
        end
        rd_if.ready_from_core = 1'b0;
        rd_if.start_read      = 1'b0;
        if (done_at < 0) chk({tag, "_done_timeout"}, 0, 1);
        chk({tag, "_done_count"}, done_cnt, 1);
        if (mode == 0 && done_at >= 0) chk({tag, "_latency_model"}, done_at, lat);
        if (exp_lat >= 0 && done_at >= 0) chk({tag, "_latency"}, done_at, exp_lat);
        if (exp_pairs >= 0) chk({tag, "_pairs"}, obs_q.size(), exp_pairs);
        chk({tag, "_pairs_model"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk($sformatf("%s_pair%0d", tag, i), obs_q[i], exp_q[i]);
    endtask

    vec_t vecs[8];
    int   rc[NS];
    int   vcnt;
    bit   hit;
    int   dn;
    int   vl;

    initial begin
        vecs[0] = '{12, 4, '{7, 2, 0, 5, 3}, 0, 4, 9};        // normal read
        vecs[1] = '{12, 4, '{7, 2, 0, 5, 3}, 1, 4, -1};       // backpressure
        vecs[2] = '{0, 4, '{1, 1, 1, 1, 1}, 0, 0, 2};         // no history, frame 0
        vecs[3] = '{7, 1, '{3, 3, 3, 3, 3}, 0, 0, 2};         // no history, nh=1
        vecs[4] = '{5, 5, '{1, 1, 1, 1, 1}, 0, 4, 10};        // wrap, slot 0 unread
        vecs[5] = '{9, 0, '{4, 4, 4, 4, 4}, 0, 0, 2};         // nh=0 behaves as 1
        vecs[6] = '{1, 2, '{255, 0, 0, 0, 0}, 0, 128, 131};   // full slot, no wrap
        vecs[7] = '{200, 5, '{3, 0, 4, 1, 2}, 2, -1, -1};     // random backpressure

        reset_N = 1'b1;
        frame_num = '0;
        nh = '0;
        ep = '0;
        rd_if.start_read = 1'b0;
        rd_if.ready_from_core = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid_read", rd_if.valid_read, 0);
        chk("rst_done_read", rd_if.done_read, 0);
        chk("rst_valid_1", rd_if.valid_1, 0);
        chk("rst_slot", rd_if.slot, 0);
        chk("rst_offset_0", rd_if.offset_0, 0);
        chk("rst_offset_1", rd_if.offset_1, 0);
        reset_N = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 8; v++) begin
            run_read($sformatf("vec%0d", v), vecs[v].fn, vecs[v].nh, vecs[v].cnt,
                     vecs[v].mode, vecs[v].exp_pairs, vecs[v].exp_lat, 1'b0);
            if (v == 0 && obs_q.size() == 4) begin
                chk("normal_p0", obs_q[0], enc(3, 0, 1, 1));
                chk("normal_p1", obs_q[1], enc(3, 2, 3, 1));
                chk("normal_p2", obs_q[2], enc(3, 4, 5, 0));
                chk("normal_p3", obs_q[3], enc(1, 0, 1, 1));
            end
        end

        // Snapshot robustness: count change and extra start_read mid-read.
        rc = '{7, 2, 0, 5, 3};
        run_read("robust", 12, 4, rc, 0, 4, 9, 1'b1);

        // Reset during the second PAIR presentation.
        frame_num = FW'(12);
        nh = HW'(4);
        ep = '0;
        ep[3] = AW'(5);
        ep[1] = AW'(2);
        rd_if.start_read = 1'b1;
        rd_if.ready_from_core = 1'b1;
        @(posedge clk); #1;
        rd_if.start_read = 1'b0;
        vcnt = 0;
        hit = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            if (rd_if.valid_read) vcnt++;
            if (vcnt == 2) begin
                hit = 1'b1;
                break;
            end
        end
        chk("rst_mid_reach_pair2", hit, 1);
        chk("rst_mid_pair2", cur_out(), enc(3, 2, 3, 1));
        reset_N = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_valid_read", rd_if.valid_read, 0);
        chk("rst_mid_done_read", rd_if.done_read, 0);
        chk("rst_mid_valid_1", rd_if.valid_1, 0);
        chk("rst_mid_slot", rd_if.slot, 0);
        chk("rst_mid_offset_0", rd_if.offset_0, 0);
        chk("rst_mid_offset_1", rd_if.offset_1, 0);
        reset_N = 1'b0;
        dn = 0;
        vl = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            dn += int'(rd_if.done_read);
            vl += int'(rd_if.valid_read);
        end
        chk("rst_mid_no_done", dn, 0);
        chk("rst_mid_no_valid", vl, 0);
        rd_if.ready_from_core = 1'b0;

        // Random reads against the reference model.
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < NS; i++) rc[i] = int'($urandom_range(0, 7));
            run_read($sformatf("rnd%0d", r), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 5)), rc, int'($urandom_range(0, 2)),
                     -1, -1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
